// File: rtl/reg_piso_tx_pkg.sv
// reg_piso_tx_pkg: state encoding and line levels for reg_piso_tx (REG_PISO_TX_PARITY_EN adds ST_PARITY)
package reg_piso_tx_pkg;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
`ifdef REG_PISO_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif
endpackage

// File: rtl/reg_piso_shift.sv
// reg_piso_shift: WIDTH-bit right shift register with load, zero fill, exposes bit 0
module reg_piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);
  logic [WIDTH-1:0] q;
  // load wins over shift; shifting moves the next bit into position 0
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= q >> 1;
  end
  assign q0 = q[0];
endmodule

// File: rtl/reg_piso_tx.sv
// reg_piso_tx: framed LSB-first serial transmitter, optional even parity via REG_PISO_TX_PARITY_EN
module reg_piso_tx
  import reg_piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] dato,
  output logic             ready,
  output logic             busy,
  output logic             salida
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic q0, ld, sh;
`ifdef REG_PISO_TX_PARITY_EN
  logic par;
`endif
  assign ready = state == ST_IDLE;
  assign busy  = !ready;
  assign ld = ready && load;
  assign sh = enable && (state == ST_START || (state == ST_DATA && cnt < CMAX));
  reg_piso_shift #(.WIDTH(WIDTH)) u_shift (
    .clk  (clk),
    .reset(reset),
    .load (ld),
    .shift(sh),
    .d    (dato),
    .q0   (q0)
  );
  // frame sequencer: load edge starts the frame, every other step waits for an enable tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      salida <= LINE_IDLE;
      cnt    <= '0;
`ifdef REG_PISO_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else if (ld) begin
      state  <= ST_START;
      salida <= LINE_START;
      cnt    <= '0;
`ifdef REG_PISO_TX_PARITY_EN
      par    <= ^dato;
`endif
    end else if (enable) begin
      case (state)
        ST_START: begin
          salida <= q0;
          cnt    <= CW'(1);
          state  <= ST_DATA;
        end
        ST_DATA: begin
          if (cnt < CMAX) begin
            salida <= q0;
            cnt    <= cnt + CW'(1);
          end else begin
`ifdef REG_PISO_TX_PARITY_EN
            salida <= par;
            state  <= ST_PARITY;
`else
            salida <= LINE_IDLE;
            state  <= ST_STOP;
`endif
          end
        end
`ifdef REG_PISO_TX_PARITY_EN
        ST_PARITY: begin
          salida <= LINE_IDLE;
          state  <= ST_STOP;
        end
`endif
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/reg_piso_tx.md
Name: reg_piso_tx

Overview:
Parallel-in, serial-out framed transmitter. It is the sending end of the serial line that the shift-register input stages sample.
- Accepts a parallel word through a load/ready handshake.
- Shifts the word out LSB first, framed by one start bit (0) and one stop bit (1).
- Advances one bit per clock edge on which `enable` is high, so the bit rate is set by an external tick.

Parameters:
- WIDTH, 4, number of data bits per frame (legal range 1..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bit-rate tick; the FSM advances only on edges where enable=1.
- load  input  1  request to transmit `dato`.
- dato  input  WIDTH  parallel word to send; sampled only on an accepted load.
- ready  output  1  high when idle and able to accept a load.
- busy  output  1  high while a frame is in progress (the complement of ready).
- salida  output  1  serial line; registered; idle level is 1.

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values: state=IDLE, salida=1, ready=1, busy=0, shift register=0, bit counter=0.
- Reset has priority over every other input, including mid-frame. The frame is aborted and salida returns to 1 on that edge.
- States: IDLE, START, DATA, STOP. The encoding is 2 bits.
- IDLE:
  - ready=1 and salida=1.
  - On an edge with load=1: capture dato into the shift register, clear the counter, set salida<=0, and go to START.
  - This edge ignores enable. The load edge is the frame start.
- START: on the next edge with enable=1, set salida<=Q[0], shift Q right (fill with 0), set counter<=1, and go to DATA.
- DATA:
  - On each enable edge, if counter<WIDTH: salida<=Q[0], shift, counter+1.
  - If counter==WIDTH: salida<=1 and go to STOP.
- STOP: on the next enable edge, go to IDLE. salida stays 1 and ready rises on that edge.
- Bit duration:
  - Each line level is held from the edge that drives it until the next edge with enable=1.
  - If enable is 0, the current bit is held indefinitely and no state changes.
- Latency with enable tied to 1:
  - Start bit occupies the cycle after the load edge.
  - Data bits d0..d(WIDTH-1) follow.
  - Stop bit follows the last data bit.
  - ready returns WIDTH+2 edges after the load edge.
  - Total frame length is WIDTH+2 bit periods.
- The earliest next accepted load is the edge on which ready=1 is first visible, i.e. the cycle after ready rises. There is no back-to-back overlap.
- Load and dato while busy=1 are ignored. The frame in progress is unaffected and no request is queued.
- ready and busy are decoded combinationally from the state register. salida is a flop output, so it is glitch-free.
- Counter width is clog2(WIDTH+1). It never wraps, because it saturates at WIDTH before the STOP transition.

Optional Feature:
- Macro REG_PISO_TX_PARITY_EN.
- Defined:
  - An extra state PARITY is inserted between DATA and STOP.
  - The line carries the even-parity bit (XOR of the captured dato, computed at load time and stored) for one enable period.
  - Frame length is WIDTH+3 and ready returns WIDTH+3 edges after load.
- Undefined: no PARITY state and no parity register. Behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_START=1, ST_DATA=2, ST_STOP=3 (ST_PARITY uses an extra encoding when enabled);
  - the line-level constants LINE_IDLE=1 and LINE_START=0.
- One natural sub-module is reg_piso_shift. It is a WIDTH-bit register with synchronous reset, load and shift-enable, and exposes Q[0].
- The FSM, counter and salida flop stay in the top module.

Test Plan:
- Basic frame: WIDTH=4, enable=1, load pulse with dato=4'b1011 → salida on the following cycles is 0,1,1,0,1,1. ready=0 for 6 edges, then 1.
- Slow tick: enable high one cycle in three, dato=4'b0110 → every bit, including start and stop, is held exactly 3 cycles; line sequence 0,0,1,1,0,1.
- Enable stalls: hold enable=0 for 10 cycles mid-DATA → salida and state are frozen. The frame resumes correctly with the remaining bits.
- Load while busy: second load with dato=4'b1111 during a 4'b0000 frame → it is ignored. The line carries 0,0,0,0,0,1 and ready rises on schedule.
- Reset mid-frame: assert reset during the 2nd data bit → salida=1 and ready=1 on that edge. A new load of 4'b1001 then sends 0,1,0,0,1,1.
- REG_PISO_TX_PARITY_EN defined, dato=4'b1011 → line sequence 0,1,1,0,1,1(parity),1(stop). ready returns after 7 edges.
